pulse_period_meter: RTL and testbench

Input-side counterpart to the LED blink generator. It samples an external square-wave input, such as a sensor or logger strobe, and measures its period and high time in i_clk cycles. Results go to the downstream SPI/logging path through a valid/ready handshake. Overrun and timeout are flagged.

---
 rtl/pulse_period_meter.sv | 128 ++++++++++++
 tb/tb_pulse_period_meter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Pulse period meter: measures the period and high time of an asynchronous square
// wave in i_clk cycles and hands each result downstream over valid/ready.
module pulse_period_meter #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 16000000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_sig,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [CNT_WIDTH-1:0] o_period,
    output logic [CNT_WIDTH-1:0] o_high_time,
    output logic                 o_timeout,
    output logic                 o_overrun,
    output logic                 o_level
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_TIMEOUT = CNT_WIDTH'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_prev;
    logic                   rise;
    logic                   fall;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   count;
    logic [CNT_WIDTH-1:0]   high_tmp;
    logic                   commit_q;
    logic [CNT_WIDTH-1:0]   commit_period;
    logic [CNT_WIDTH-1:0]   commit_high;

    // Metastability chain plus one-cycle history for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q     <= '0;
            level_prev <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], i_sig};
            level_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_level = sync_q[SYNC_STAGES-1];
    assign rise    = o_level & ~level_prev;
    assign fall    = ~o_level & level_prev;

    // Measurement FSM; a finished period is staged in commit_* for one cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            count         <= '0;
            high_tmp      <= '0;
            commit_q      <= 1'b0;
            commit_period <= '0;
            commit_high   <= '0;
            o_timeout     <= 1'b0;
        end else if (!i_en) begin
            state     <= IDLE;
            count     <= '0;
            commit_q  <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            case (state)
                IDLE: state <= ARM;
                ARM: begin
                    if (rise) begin
                        count <= CNT_ONE;
                        state <= MEAS;
                    end
                end
                MEAS: begin
                    if (fall) begin
                        high_tmp <= count;
                    end
                    if (rise) begin
                        commit_q      <= 1'b1;
                        commit_period <= count;
                        commit_high   <= high_tmp;
                        count         <= CNT_ONE;
                        o_timeout     <= 1'b0;
                    end else if (count == CNT_TIMEOUT) begin
                        o_timeout <= 1'b1;
                        count     <= '0;
                        state     <= ARM;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result register: a commit is dropped only when the held result is not being taken
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_period    <= '0;
            o_high_time <= '0;
            o_overrun   <= 1'b0;
        end else if (!i_en) begin
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else if (commit_q) begin
            if (!o_valid || i_ready) begin
                o_period    <= commit_period;
                o_high_time <= commit_high;
                o_valid     <= 1'b1;
            end else begin
                o_overrun <= 1'b1;
            end
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: directed tables and sequences plus random stimulus
// checked every cycle against a timestamp-based reference model.
module tb_pulse_period_meter;

    localparam int CNT_W   = 32;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 50;

    logic             clk;
    logic             i_rst;
    logic             i_en;
    logic             i_sig;
    logic             i_ready;
    logic             o_valid;
    logic [CNT_W-1:0] o_period;
    logic [CNT_W-1:0] o_high_time;
    logic             o_timeout;
    logic             o_overrun;
    logic             o_level;

    pulse_period_meter #(
        .CNT_WIDTH  (CNT_W),
        .SYNC_STAGES(SYNC),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_sig      (i_sig),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_period   (o_period),
        .o_high_time(o_high_time),
        .o_timeout  (o_timeout),
        .o_overrun  (o_overrun),
        .o_level    (o_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: levels come from a delay queue of samples, measurements from
    // edge timestamps, results from a one-deep pending slot feeding the output.
    bit m_q[$];
    bit m_lvl, m_lvl_prev;
    int m_mode;  // 0 disabled, 1 waiting for first rise, 2 measuring
    int m_edge, m_t_rise, m_hi;
    bit m_pend;
    int m_pp, m_ph;
    bit m_valid, m_timeout, m_overrun;
    int m_period, m_high;
    bit model_on = 1'b0;

    task automatic model_step(input bit rst, input bit en, input bit sig, input bit rdy);
        bit rise, fall;
        m_edge++;
        if (rst) begin
            m_q.delete();
            m_lvl = 0; m_lvl_prev = 0; m_mode = 0; m_hi = 0;
            m_pend = 0; m_pp = 0; m_ph = 0;
            m_valid = 0; m_timeout = 0; m_overrun = 0; m_period = 0; m_high = 0;
            return;
        end
        rise = m_lvl && !m_lvl_prev;
        fall = !m_lvl && m_lvl_prev;
        if (!en) begin
            m_mode = 0; m_valid = 0; m_timeout = 0; m_overrun = 0; m_pend = 0;
        end else begin
            if (m_pend) begin
                if (!m_valid || rdy) begin
                    m_period = m_pp; m_high = m_ph; m_valid = 1;
                end else begin
                    m_overrun = 1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
            m_pend = 0;
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (rise) begin
                    m_t_rise = m_edge; m_mode = 2;
                end
            end else begin
                if (fall) m_hi = m_edge - m_t_rise;
                if (rise) begin
                    m_pend = 1; m_pp = m_edge - m_t_rise; m_ph = m_hi;
                    m_t_rise = m_edge; m_timeout = 0;
                end else if (m_edge - m_t_rise == TIMEOUT) begin
                    m_timeout = 1; m_mode = 1;
                end
            end
        end
        m_q.push_back(sig);
        if (m_q.size() > SYNC) void'(m_q.pop_front());
        m_lvl_prev = m_lvl;
        m_lvl = (m_q.size() == SYNC) ? m_q[0] : 1'b0;
    endtask

    // One clock: drive inputs, advance model, compare every output just after the edge
    task automatic tick(input bit t_rst, input bit t_en, input bit t_sig, input bit t_rdy);
        i_rst = t_rst; i_en = t_en; i_sig = t_sig; i_ready = t_rdy;
        @(posedge clk);
        model_step(t_rst, t_en, t_sig, t_rdy);
        #1;
        if (t_rst) model_on = 1'b1;
        if (model_on) begin
            chk("m_valid",   32'(o_valid),   32'(m_valid));
            chk("m_period",  o_period,       32'(m_period));
            chk("m_high",    o_high_time,    32'(m_high));
            chk("m_timeout", 32'(o_timeout), 32'(m_timeout));
            chk("m_overrun", 32'(o_overrun), 32'(m_overrun));
            chk("m_level",   32'(o_level),   32'(m_lvl));
        end
    endtask

    task automatic restart();
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
    endtask

    typedef struct {
        bit rst, en, sig, ready;
        bit exp_valid, exp_level;
    } rst_vec_t;

    typedef struct {
        int period, high;
        int exp_period, exp_high;
    } wave_t;

    rst_vec_t rtab[8];
    wave_t    wtab[7];
    int first_v, nvalid, bad, cap_p, cap_h;
    int run;
    bit s_r, en_r, rst_r, rdy_r;

    initial begin
        i_rst = 1; i_en = 0; i_sig = 0; i_ready = 0;

        rtab[0] = '{1, 1, 1, 1, 0, 0};
        rtab[1] = '{1, 1, 0, 1, 0, 0};
        rtab[2] = '{1, 1, 1, 1, 0, 0};
        rtab[3] = '{0, 0, 1, 0, 0, 0};
        rtab[4] = '{0, 0, 1, 0, 0, 1};
        rtab[5] = '{0, 0, 0, 0, 0, 1};
        rtab[6] = '{0, 0, 0, 0, 0, 0};
        rtab[7] = '{0, 0, 0, 0, 0, 0};

        wtab[0] = '{10, 4, 10, 4};
        wtab[1] = '{7, 1, 7, 1};
        wtab[2] = '{15, 9, 15, 9};
        wtab[3] = '{3, 1, 3, 1};
        wtab[4] = '{2, 1, 2, 1};
        wtab[5] = '{49, 20, 49, 20};
        wtab[6] = '{50, 25, 50, 25};

        // Reset values and idle behaviour
        foreach (rtab[i]) begin
            tick(rtab[i].rst, rtab[i].en, rtab[i].sig, rtab[i].ready);
            chk("rst_valid",   32'(o_valid),   32'(rtab[i].exp_valid));
            chk("rst_level",   32'(o_level),   32'(rtab[i].exp_level));
            chk("rst_period",  o_period,       32'd0);
            chk("rst_high",    o_high_time,    32'd0);
            chk("rst_timeout", 32'(o_timeout), 32'd0);
            chk("rst_overrun", 32'(o_overrun), 32'd0);
        end

        // Steady square wave: latency and pulse spacing
        restart();
        first_v = -1; nvalid = 0; bad = 0; cap_p = -1; cap_h = -1;
        for (int k = 0; k < 60; k++) begin
            tick(0, 1, (k % 10) < 4, 1);
            if (o_valid) begin
                if (first_v < 0) begin
                    first_v = k; cap_p = int'(o_period); cap_h = int'(o_high_time);
                end
                if ((k - 13) % 10 != 0) bad++;
                nvalid++;
            end
        end
        chk("sq_first_valid", 32'(first_v), 32'd13);
        chk("sq_period",      32'(cap_p),   32'd10);
        chk("sq_high",        32'(cap_h),   32'd4);
        chk("sq_pulses",      32'(nvalid),  32'd5);
        chk("sq_spacing",     32'(bad),     32'd0);

        // Wave table, including the period equal to TIMEOUT
        foreach (wtab[i]) begin
            restart();
            cap_p = -1; cap_h = -1;
            for (int k = 0; k < 3 * wtab[i].period + 6; k++) begin
                tick(0, 1, (k % wtab[i].period) < wtab[i].high, 1);
                if (o_valid) begin
                    cap_p = int'(o_period); cap_h = int'(o_high_time);
                end
            end
            chk("wave_period", 32'(cap_p), 32'(wtab[i].exp_period));
            chk("wave_high",   32'(cap_h), 32'(wtab[i].exp_high));
        end

        // Backpressure and overrun
        restart();
        for (int k = 0; k < 56; k++) begin
            tick(0, 1, (k % 12) < 5, k == 40);
            if (k == 26) chk("bp_no_overrun_yet", 32'(o_overrun), 32'd0);
            if (k == 39) begin
                chk("bp_valid",   32'(o_valid),   32'd1);
                chk("bp_period",  o_period,       32'd12);
                chk("bp_high",    o_high_time,    32'd5);
                chk("bp_overrun", 32'(o_overrun), 32'd1);
            end
            if (k == 40) begin
                chk("bp_drop_valid",  32'(o_valid),   32'd0);
                chk("bp_overrun_hold", 32'(o_overrun), 32'd1);
            end
            if (k == 55) begin
                chk("bp_next_valid",  32'(o_valid),   32'd1);
                chk("bp_overrun_sticky", 32'(o_overrun), 32'd1);
            end
        end
        tick(0, 0, 0, 0);
        chk("bp_en_clr_overrun", 32'(o_overrun), 32'd0);
        chk("bp_en_clr_valid",   32'(o_valid),   32'd0);

        // Accept coinciding with a commit
        restart();
        for (int k = 0; k < 23; k++) begin
            tick(0, 1, (k < 3) || (k >= 8 && k < 11) || (k >= 17 && k < 20), k == 20);
            if (k == 19) chk("co_period_first", o_period, 32'd8);
            if (k == 20) begin
                chk("co_period_second", o_period,       32'd9);
                chk("co_valid",         32'(o_valid),   32'd1);
                chk("co_overrun",       32'(o_overrun), 32'd0);
                chk("co_high",          o_high_time,    32'd3);
            end
        end

        // Timeout and recovery
        restart();
        for (int k = 0; k < 86; k++) begin
            tick(0, 1, (k <= 52) || (k >= 60 && k < 65) || (k >= 80 && k < 85), 1);
            if (k == 51) chk("to_before", 32'(o_timeout), 32'd0);
            if (k == 52) chk("to_set",    32'(o_timeout), 32'd1);
            if (k == 81) chk("to_held",   32'(o_timeout), 32'd1);
            if (k == 83) begin
                chk("to_valid",   32'(o_valid),   32'd1);
                chk("to_period",  o_period,       32'd20);
                chk("to_high",    o_high_time,    32'd5);
                chk("to_cleared", 32'(o_timeout), 32'd0);
            end
        end

        // Abort by enable drop, then by reset, each mid-period
        restart();
        bad = 0;
        for (int k = 0; k < 76; k++) begin
            tick(k == 55, k != 25, (k % 10) < 4, k >= 26);
            if (k == 23) chk("ab_overrun_set", 32'(o_overrun), 32'd1);
            if (k == 25) begin
                chk("ab_en_valid",   32'(o_valid),   32'd0);
                chk("ab_en_overrun", 32'(o_overrun), 32'd0);
            end
            if (((k >= 26 && k <= 42) || (k >= 55 && k <= 72)) && o_valid) bad++;
            if (k == 43 || k == 73) begin
                chk("ab_valid",  32'(o_valid), 32'd1);
                chk("ab_period", o_period,     32'd10);
                chk("ab_high",   o_high_time,  32'd4);
            end
            if (k == 55) begin
                chk("ab_rst_period", o_period,       32'd0);
                chk("ab_rst_level",  32'(o_level),   32'd0);
                chk("ab_rst_valid",  32'(o_valid),   32'd0);
            end
        end
        chk("ab_no_early_result", 32'(bad), 32'd0);

        // Random stimulus against the model
        run = 0; s_r = 0;
        for (int k = 0; k < 4000; k++) begin
            if (run == 0) begin
                s_r = !s_r;
                run = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 70))
                                                  : int'($urandom_range(1, 20));
            end
            run--;
            en_r  = ($urandom_range(0, 199) != 0);
            rst_r = ($urandom_range(0, 499) == 0);
            rdy_r = ($urandom_range(0, 3) != 0);
            tick(rst_r, en_r, s_r, rdy_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
